// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instruction_fetch_unit_pkg;

   localparam int unsigned XLEN        = 64;
   localparam int unsigned INSTR_BYTES = 4;
   // addi x0,x0,0: decodes to the control unit's do-nothing default
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, instr}; flush beats push/pop.
module instruction_fetch_unit_fetch_fifo
   import instruction_fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  fetch_entry_t               push_data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output fetch_entry_t               head_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   fetch_entry_t      mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              push_ok, pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i && !full_o && !flush_i;
   assign pop_ok  = pop_i && !empty_o && !flush_i;

   // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // Pointer/occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible once counted
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: credit-limited in-order imem requests, response buffering,
// decode handshake and branch redirect with drop of in-flight responses.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [31:0]     dec_instruction,
   output logic [XLEN-1:0] dec_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   localparam int unsigned CW  = $clog2(2*FIFO_DEPTH+1);
   localparam int unsigned FCW = $clog2(FIFO_DEPTH+1);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_q, drop_d;

   logic            fifo_full, fifo_empty;
   logic [FCW-1:0]  fifo_count;
   fetch_entry_t    fifo_head, push_entry;
   logic            accept, rsp_drop, rsp_keep, pop, push;
   logic [XLEN-1:0] redirect_target;

   // Credit covers buffered plus live in-flight requests, so a kept response always fits.
   // Held low while reset is asserted.
   assign imem_req_valid  = rst_n && ((CW'(fifo_count) + outstanding_q) < CW'(FIFO_DEPTH));
   assign imem_req_addr   = pc_q;
   assign accept          = imem_req_valid && imem_req_ready;
   assign rsp_drop        = imem_rsp_valid && (drop_q != '0);
   assign rsp_keep        = imem_rsp_valid && (drop_q == '0) && (outstanding_q != '0);
   assign push            = rsp_keep && !fifo_full;
   assign pop             = dec_valid && dec_ready;
   assign redirect_target = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
   assign push_entry      = '{pc: rsp_pc_q, instr: imem_rsp_data};

   assign dec_valid       = !fifo_empty;
   assign dec_instruction = fifo_empty ? NOP_INSTR : fifo_head.instr;
   assign dec_pc          = fifo_empty ? '0 : fifo_head.pc;

   // Next-state for PCs and request/drop counters; a redirect turns everything in flight into drops
   always_comb begin
      pc_d          = pc_q;
      rsp_pc_d      = rsp_pc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      if (redirect_valid) begin
         pc_d          = redirect_target;
         rsp_pc_d      = redirect_target;
         outstanding_d = '0;
         drop_d        = drop_q + outstanding_q + CW'(accept) - CW'(rsp_drop || rsp_keep);
      end else begin
         if (accept)   pc_d     = pc_q + XLEN'(INSTR_BYTES);
         if (rsp_keep) rsp_pc_d = rsp_pc_q + XLEN'(INSTR_BYTES);
         outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_keep);
         drop_d        = drop_q - CW'(rsp_drop);
      end
   end

   // Fetch state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         pc_q          <= pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   instruction_fetch_unit_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fetch_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (redirect_valid),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count),
      .head_o      (fifo_head)
   );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed phases plus randomized traffic,
// checked against a stream-level model (next PC to decode, next request PC, live requests).
module tb_instruction_fetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [63:0] RST_PC   = 64'h0;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid, imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        dec_valid, dec_ready;
   logic [31:0] dec_instruction;
   logic [63:0] dec_pc;
   logic        redirect_valid;
   logic [63:0] redirect_pc;

   always #5 clk = ~clk;

   instruction_fetch_unit #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .dec_valid       (dec_valid),
      .dec_ready       (dec_ready),
      .dec_instruction (dec_instruction),
      .dec_pc          (dec_pc),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc)
   );

   typedef struct {
      logic [63:0] addr;
      int          cyc;
   } pend_t;

   pend_t       mq[$];
   int          checks = 0, errors = 0;
   int          cyc = 0;
   logic [63:0] exp_pc, exp_req;
   int          live;
   int          p_ready, p_rsp, p_dec, p_redir;
   bit          force_redirect = 0;
   logic [63:0] force_target;
   int          n_pop = 0;

   function automatic logic [31:0] instr_of(logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0001;
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_req_valid"}, imem_req_valid, 1'b0);
      check({tag, "_dec_valid"}, dec_valid, 1'b0);
      check({tag, "_dec_instr"}, dec_instruction, NOP);
      check({tag, "_dec_pc"}, dec_pc, 64'h0);
   endtask

   task automatic model_reset();
      mq.delete();
      exp_pc  = RST_PC;
      exp_req = RST_PC;
      live    = 0;
   endtask

   // Assert reset between clock edges; outputs must take reset values at once
   task automatic async_reset(string tag);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs(tag);
      model_reset();
   endtask

   // One clock cycle: drive inputs at the falling edge, check, then advance the model at the rising edge
   task automatic step();
      bit          acc, pop, redir;
      logic [63:0] tgt, addr_s;
      @(negedge clk);
      rst_n          = 1'b1;
      imem_req_ready = ($urandom_range(99) < p_ready);
      if (mq.size() > 0 && mq[0].cyc < cyc && $urandom_range(99) < p_rsp) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = instr_of(mq[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      dec_ready      = ($urandom_range(99) < p_dec);
      redir          = force_redirect || ($urandom_range(999) < p_redir);
      tgt            = force_redirect ? force_target : {$urandom, $urandom};
      force_redirect = 0;
      redirect_valid = redir;
      redirect_pc    = tgt;
      #1;
      check("req_valid", imem_req_valid, (live < DEPTH));
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_req);
      if (dec_valid) begin
         check("dec_pc", dec_pc, exp_pc);
         check("dec_instr", dec_instruction, instr_of(exp_pc));
      end else begin
         check("idle_instr", dec_instruction, NOP);
         check("idle_pc", dec_pc, 64'h0);
      end
      acc    = imem_req_valid && imem_req_ready;
      pop    = dec_valid && dec_ready;
      addr_s = imem_req_addr;
      @(posedge clk);
      if (imem_rsp_valid) void'(mq.pop_front());
      if (acc) mq.push_back('{addr: addr_s, cyc: cyc});
      if (pop) begin
         exp_pc = exp_pc + 64'd4;
         n_pop++;
      end
      if (redir) begin
         exp_pc  = tgt & ~64'h3;
         exp_req = tgt & ~64'h3;
         live    = 0;
      end else begin
         if (acc) exp_req = exp_req + 64'd4;
         live = live + int'(acc) - int'(pop);
      end
      cyc++;
   endtask

   task automatic set_knobs(int rdy, int rsp, int dec, int redir);
      p_ready = rdy;
      p_rsp   = rsp;
      p_dec   = dec;
      p_redir = redir;
   endtask

   initial begin
      int  n0;
      bit  found;
      rst_n          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      dec_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      set_knobs(100, 100, 100, 0);
      #3;
      check_reset_outputs("reset");
      model_reset();

      // 1: streaming from RESET_PC, steady progress once filled
      repeat (20) step();
      n0 = n_pop;
      repeat (10) step();
      check("t1_progress", (n_pop - n0) >= 6, 1'b1);

      // 2: decode stalled -> buffer fills and requests stop
      set_knobs(100, 100, 0, 0);
      repeat (10) step();
      #1;
      check("t2_req_blocked", imem_req_valid, 1'b0);
      check("t2_dec_valid", dec_valid, 1'b1);
      set_knobs(100, 100, 100, 0);
      repeat (10) step();

      // 3: imem stalls -> address and valid held
      set_knobs(0, 100, 100, 0);
      repeat (5) step();
      set_knobs(100, 100, 100, 0);
      repeat (5) step();

      // 4: redirect with requests in flight (responses withheld)
      async_reset("t4_reset");
      set_knobs(100, 0, 100, 0);
      repeat (3) step();
      force_redirect = 1;
      force_target   = 64'h1002;
      step();
      #1;
      check("t4_req_valid", imem_req_valid, 1'b1);
      check("t4_req_addr", imem_req_addr, 64'h1000);
      set_knobs(100, 100, 100, 0);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         #1;
         if (dec_valid) begin
            found = 1;
            check("t4_first_pc", dec_pc, 64'h1000);
         end
      end
      check("t4_found", found, 1'b1);

      // 5: redirect in a cycle with both a pop and a kept push
      repeat (10) step();
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         #1;
         if (dec_valid && mq.size() > 0 && mq[0].cyc < cyc) begin
            found          = 1;
            force_redirect = 1;
            force_target   = 64'h2000;
            step();
            #1;
            check("t5_empty_after", dec_valid, 1'b0);
         end else begin
            step();
         end
      end
      check("t5_found", found, 1'b1);
      repeat (10) step();

      // 6: asynchronous reset mid-stream, then restart at RESET_PC
      async_reset("t6_reset");
      repeat (20) step();

      // wrap-around of the PC at the top of the address space
      force_redirect = 1;
      force_target   = 64'hFFFF_FFFF_FFFF_FFF6;
      step();
      repeat (20) step();

      // randomized traffic with occasional redirects and one reset
      set_knobs(70, 60, 70, 30);
      n0 = n_pop;
      repeat (1500) step();
      async_reset("rand_reset");
      repeat (1500) step();
      check("rand_progress", (n_pop - n0) > 200, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
